// File: rtl/present_masked_round_ctrl_pkg.sv
// Shared definitions for the masked PRESENT round controller:
// FSM state encoding, round-counter sizing and the control-word layout.
package present_masked_round_ctrl_pkg;

  localparam int PRESENT_ROUNDS  = 31;
  localparam int RCNT_W          = 5;
  localparam int MAX_SBOX_STAGES = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SBOX   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Every control strobe decoded from the FSM state.
  typedef struct packed {
    logic busy;
    logic done;
    logic sel_load;
    logic en_state;
    logic en_key;
    logic en_sbox;
    logic final_add;
  } ctrl_t;

  // Counter width for a modulo-n count; a modulo-1 counter still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/present_masked_round_ctrl_stage_counter.sv
// Modulo-N counter with enable and clear; tc flags the last count so the
// caller knows the S-box pipeline has been fully advanced.
module ctrl_stage_counter
  import present_masked_round_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int            W    = cnt_width(N);
  localparam logic [W-1:0]  LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  // Count enabled cycles, wrapping to zero after the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/present_masked_round_ctrl.sv
// Round controller for the second-order masked PRESENT core. Sequences the
// share registers, the pipelined masked S-box, the pLayer/key-add path and
// the key schedule. All outputs are Moore-decoded from registered state.
module present_masked_round_ctrl
  import present_masked_round_ctrl_pkg::*;
#(
  parameter int ROUNDS      = 31,
  parameter int SBOX_STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sel_load,
  output logic              en_state,
  output logic              en_key,
  output logic              en_sbox,
  output logic              final_add,
  output logic [RCNT_W-1:0] round_cnt
);

  // Configuration sanity check, evaluated at elaboration.
  if (ROUNDS < 1 || ROUNDS > PRESENT_ROUNDS) begin : g_bad_rounds
    $error("present_masked_round_ctrl: ROUNDS=%0d outside 1..%0d", ROUNDS, PRESENT_ROUNDS);
  end
  if (SBOX_STAGES < 1 || SBOX_STAGES > MAX_SBOX_STAGES) begin : g_bad_stages
    $error("present_masked_round_ctrl: SBOX_STAGES=%0d outside 1..%0d", SBOX_STAGES, MAX_SBOX_STAGES);
  end

  localparam logic [RCNT_W-1:0] LAST_ROUND = RCNT_W'(ROUNDS);

  state_e            state, state_nxt;
  logic [RCNT_W-1:0] rcnt_q;
  logic              stage_tc;
  ctrl_t             ctrl;

  // Stage counter advances only while the S-box pipeline is being clocked.
  ctrl_stage_counter #(
    .N (SBOX_STAGES)
  ) u_stage_cnt (
    .clk (clk),
    .rst (rst),
    .en  (state == ST_SBOX),
    .clr (state != ST_SBOX),
    .tc  (stage_tc)
  );

  // State register; reset aborts any encryption immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_SBOX;
      ST_SBOX:   if (stage_tc) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = (rcnt_q == LAST_ROUND) ? ST_FINAL : ST_SBOX;
      ST_FINAL:  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the registered state only.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_LOAD: begin
        ctrl.busy     = 1'b1;
        ctrl.sel_load = 1'b1;
        ctrl.en_state = 1'b1;
        ctrl.en_key   = 1'b1;
      end
      ST_SBOX: begin
        ctrl.busy    = 1'b1;
        ctrl.en_sbox = 1'b1;
      end
      ST_UPDATE: begin
        ctrl.busy     = 1'b1;
        ctrl.en_state = 1'b1;
        ctrl.en_key   = 1'b1;
      end
      ST_FINAL: begin
        ctrl.busy      = 1'b1;
        ctrl.final_add = 1'b1;
        ctrl.en_state  = 1'b1;
      end
      ST_DONE: begin
        ctrl.busy = 1'b1;
        ctrl.done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Round counter: 1 after LOAD, bumps on every non-final UPDATE, cleared after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
    end else begin
      case (state)
        ST_LOAD:   rcnt_q <= RCNT_W'(1);
        ST_UPDATE: if (rcnt_q != LAST_ROUND) rcnt_q <= rcnt_q + 1'b1;
        ST_DONE:   rcnt_q <= '0;
        default:   rcnt_q <= rcnt_q;
      endcase
    end
  end

  assign busy      = ctrl.busy;
  assign done      = ctrl.done;
  assign sel_load  = ctrl.sel_load;
  assign en_state  = ctrl.en_state;
  assign en_key    = ctrl.en_key;
  assign en_sbox   = ctrl.en_sbox;
  assign final_add = ctrl.final_add;
  assign round_cnt = rcnt_q;

endmodule

// File: tb/tb_present_masked_round_ctrl.sv
// Self-checking bench for present_masked_round_ctrl. Three instances cover
// the default configuration and the two sweep corners; a cycle-position
// reference model checks every output of every instance on every cycle.
module tb_present_masked_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_w [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       sel_w   [3];
  logic       enst_w  [3];
  logic       enk_w   [3];
  logic       ensb_w  [3];
  logic       fa_w    [3];
  logic [4:0] rc_w    [3];

  int pr [3] = '{31, 1, 31};
  int ps [3] = '{4, 1, 8};

  present_masked_round_ctrl #(.ROUNDS(31), .SBOX_STAGES(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .sel_load(sel_w[0]), .en_state(enst_w[0]), .en_key(enk_w[0]), .en_sbox(ensb_w[0]),
    .final_add(fa_w[0]), .round_cnt(rc_w[0]));

  present_masked_round_ctrl #(.ROUNDS(1), .SBOX_STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .sel_load(sel_w[1]), .en_state(enst_w[1]), .en_key(enk_w[1]), .en_sbox(ensb_w[1]),
    .final_add(fa_w[1]), .round_cnt(rc_w[1]));

  present_masked_round_ctrl #(.ROUNDS(31), .SBOX_STAGES(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .sel_load(sel_w[2]), .en_state(enst_w[2]), .en_key(enk_w[2]), .en_sbox(ensb_w[2]),
    .final_add(fa_w[2]), .round_cnt(rc_w[2]));

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Output word: {busy, done, sel_load, en_state, en_key, en_sbox, final_add, round_cnt}
  function automatic logic [11:0] mk(input bit b, input bit d, input bit sl, input bit es,
                                     input bit ek, input bit eb, input bit fa, input int rc);
    return {b, d, sl, es, ek, eb, fa, 5'(rc)};
  endfunction

  function automatic logic [11:0] act_of(input int i);
    return {busy_w[i], done_w[i], sel_w[i], enst_w[i], enk_w[i], ensb_w[i], fa_w[i], rc_w[i]};
  endfunction

  // Reference model: t is the number of cycles since start was accepted
  // (0 = idle). Outputs follow from the position of t within the schedule
  // LOAD, R x (S S-box cycles + 1 update), FINAL, DONE.
  function automatic logic [11:0] model_out(input int t, input int r, input int s);
    int last, k, rnd;
    last = 3 + r * (s + 1);
    if (t == 0)        return '0;
    if (t == 1)        return mk(1, 0, 1, 1, 1, 0, 0, 0);
    if (t == last)     return mk(1, 1, 0, 0, 0, 0, 0, r);
    if (t == last - 1) return mk(1, 0, 0, 1, 0, 0, 1, r);
    k   = t - 2;
    rnd = k / (s + 1) + 1;
    if ((k % (s + 1)) < s) return mk(1, 0, 0, 0, 0, 1, 0, rnd);
    return mk(1, 0, 0, 1, 1, 0, 0, rnd);
  endfunction

  function automatic int model_next(input int t, input logic st, input int r, input int s);
    if (t == 0) return st ? 1 : 0;
    if (t == 3 + r * (s + 1)) return 0;
    return t + 1;
  endfunction

  int mt [3] = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 3; i++) mt[i] <= 0;
    else     for (int i = 0; i < 3; i++) mt[i] <= model_next(mt[i], start_w[i], pr[i], ps[i]);
  end

  // Per-cycle comparison against the model plus the exclusivity rules.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [11:0] a;
        a = act_of(i);
        check($sformatf("model_dut%0d", i), 32'(a), 32'(model_out(mt[i], pr[i], ps[i])));
        check($sformatf("exclusive_dut%0d", i),
              {30'd0, sel_w[i] & fa_w[i], ensb_w[i] & enst_w[i]}, 32'd0);
      end
    end
  end

  // Waits for done on instance i; returns cycles elapsed (-1 on timeout).
  task automatic wait_done(input int i, input int bound, input bit hold, output int n);
    n = -1;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (!hold) start_w[i] = 1'b0;
      if (done_w[i]) begin
        n = c;
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int c;
    for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
    c = 0;
    while ((busy_w[0] || busy_w[1] || busy_w[2]) && c < 400) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check("idle_reached", {31'd0, busy_w[0] | busy_w[1] | busy_w[2]}, 32'd0);
  endtask

  typedef struct {
    int          cyc;
    logic        start;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n, n2, cur, dcount, dcyc, d1, d2;

    vecs[0]  = '{0,   1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1,   1'b0, mk(1, 0, 1, 1, 1, 0, 0, 0)};
    vecs[2]  = '{2,   1'b0, mk(1, 0, 0, 0, 0, 1, 0, 1)};
    vecs[3]  = '{5,   1'b0, mk(1, 0, 0, 0, 0, 1, 0, 1)};
    vecs[4]  = '{6,   1'b0, mk(1, 0, 0, 1, 1, 0, 0, 1)};
    vecs[5]  = '{7,   1'b0, mk(1, 0, 0, 0, 0, 1, 0, 2)};
    vecs[6]  = '{11,  1'b0, mk(1, 0, 0, 1, 1, 0, 0, 2)};
    vecs[7]  = '{152, 1'b0, mk(1, 0, 0, 0, 0, 1, 0, 31)};
    vecs[8]  = '{156, 1'b0, mk(1, 0, 0, 1, 1, 0, 0, 31)};
    vecs[9]  = '{157, 1'b0, mk(1, 0, 0, 1, 0, 0, 1, 31)};
    vecs[10] = '{158, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 31)};
    vecs[11] = '{159, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("reset_state_dut%0d", i), 32'(act_of(i)), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset then idle for 20 cycles.
    repeat (20) begin
      @(negedge clk);
      check("idle_outputs", 32'(act_of(0)), 32'd0);
    end

    // Table-driven single encryption on the default instance.
    cur = 0;
    for (int v = 0; v < 12; v++) begin
      while (cur < vecs[v].cyc) begin
        @(negedge clk);
        start_w[0] = 1'b0;
        cur++;
      end
      check($sformatf("table_cycle%0d", vecs[v].cyc), 32'(act_of(0)), 32'(vecs[v].exp));
      start_w[0] = vecs[v].start;
    end
    wait_idle();

    // start held high: back-to-back encryptions with one IDLE cycle between.
    start_w[0] = 1'b1;
    wait_done(0, 400, 1'b1, d1);
    wait_done(0, 400, 1'b1, d2);
    start_w[0] = 1'b0;
    check("b2b_first_done", 32'(d1), 32'd158);
    check("b2b_period", 32'(d2), 32'd159);
    wait_idle();

    // Starts pulsed while busy are ignored.
    start_w[0] = 1'b1;
    dcount = 0;
    dcyc = -1;
    for (int c = 1; c <= 170; c++) begin
      @(negedge clk);
      start_w[0] = (c == 10 || c == 100);
      if (done_w[0]) begin
        dcount++;
        dcyc = c;
      end
    end
    start_w[0] = 1'b0;
    check("ignored_start_done_count", 32'(dcount), 32'd1);
    check("ignored_start_done_cycle", 32'(dcyc), 32'd158);
    wait_idle();

    // Reset in cycle 70 aborts; restart in cycle 75.
    start_w[0] = 1'b1;
    dcount = 0;
    for (int c = 1; c <= 74; c++) begin
      @(negedge clk);
      start_w[0] = 1'b0;
      if (c == 70) begin
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", 32'(act_of(0)), 32'd0);
      end
      if (c == 71) rst = 1'b0;
      if (done_w[0]) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    @(negedge clk);
    start_w[0] = 1'b1;
    wait_done(0, 400, 1'b0, n);
    check("restart_done_latency", 32'(n), 32'd158);
    wait_idle();

    // Parameter corners: ROUNDS=1/SBOX_STAGES=1 and ROUNDS=31/SBOX_STAGES=8.
    start_w[1] = 1'b1;
    start_w[2] = 1'b1;
    n = -1;
    n2 = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start_w[1] = 1'b0;
      start_w[2] = 1'b0;
      if (done_w[1] && n < 0)  n = c;
      if (done_w[2] && n2 < 0) n2 = c;
      if (n >= 0 && n2 >= 0) break;
    end
    check("sweep_r1_s1_latency", 32'(n), 32'd5);
    check("sweep_r31_s8_latency", 32'(n2), 32'd282);
    wait_idle();

    // Random start traffic on all instances, checked by the monitor.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) start_w[i] = ($urandom_range(0, 15) == 0);
    end
    wait_idle();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
